data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Data RAM responder on the CPU's load/store bus; it is the slave end of the data address, data and select/load/clear pins.
- Holds DEPTH words of DATA_W bits.
- Serves loads combinationally and stores on the clock edge.
- Runs a multi-cycle clear sweep when the CPU asserts its clear line, reporting busy while sweeping.

Parameters:
ADDR_W, 12, address width in bits; matches the CPU data address bus.
DATA_W, 16, word width in bits.
DEPTH, 4096, number of words; must be at most 2^ADDR_W.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
res  input  1  synchronous, active-high reset.
dataAddr  input  ADDR_W  word address from the CPU.
dataIn  input  DATA_W  store data from the CPU (the CPU's dataOut).
dataOut  output  DATA_W  load data to the CPU (the CPU's dataIn).
selData  input  1  access select; high means load or store this cycle.
ldData  input  1  with selData high: 1 means load, 0 means store.
clrData  input  1  clear request (level; sampled each edge).
busy  output  1  high while the clear sweep runs.
err  output  1  sticky; set when an access is attempted while busy or with dataAddr >= DEPTH.

Behaviour:
- Reset: res high at an edge gives state=IDLE, clrPtr=0, busy=0, err=0. Memory contents are untouched. res has priority over every other input.
- Reset, dataOut: dataOut is combinational and is not a reset-held output.
- Load: selData=1, ldData=1, state=IDLE, address in range. Then dataOut = mem[dataAddr] combinationally, in the same cycle, with 0 cycles of latency. The CPU writes this value into its register file on the same edge.
- Idle output: when there is no valid load, dataOut = 0.
- Store: selData=1, ldData=0, state=IDLE, address in range. Then mem[dataAddr] <= dataIn at the rising edge.
- Read-during-write: a load and a store cannot coincide, because ldData selects exactly one of them. A load in the cycle after a store to the same address returns the new data.
- Out-of-range address (dataAddr >= DEPTH): a store is dropped and a load returns 0. err is set at the edge. This cannot occur when DEPTH = 2^ADDR_W.
- FSM states: IDLE, CLEARING.
- IDLE -> CLEARING: at an edge with clrData=1 (and res=0). clrPtr <= 0 and busy becomes 1 from the next cycle.
- CLEARING, each edge: mem[clrPtr] <= 0, then clrPtr <= clrPtr+1.
- CLEARING -> IDLE: at the edge where clrPtr = DEPTH-1 is written. busy = 0 in the next cycle. The sweep takes exactly DEPTH cycles of busy=1.
- clrData=1 while CLEARING: the sweep restarts, with clrPtr <= 0 at that edge and the current word still zeroed. The CPU holds clear for several cycles during reset, so the sweep completes DEPTH cycles after the last clrData-high edge.
- Access while busy: selData=1 while busy=1 sets err. The store is dropped and dataOut = 0.
- Access with clrData=1 in IDLE: clear wins. The store in that cycle is dropped and err is not set; a load still returns the old data combinationally.
- clrPtr width: clog2(DEPTH)+1 bits, so the compare with DEPTH-1 has no wrap.
- err clears only on res.

Decomposition:
- Shared package: state encoding for IDLE=1'b0 and CLEARING=1'b1, plus the default constants ADDR_W=12 and DATA_W=16, which are shared with the CPU data bus.
- One natural sub-module, mem_array: a DEPTH x DATA_W storage with one async read port and one sync write port.
- The top level muxes the write port between the CPU store and the clear sweep, and holds the FSM and clrPtr.

Test Plan:
- Store then load: store 16'hBEEF to addr 12'h005, then load addr 5 the next cycle -> dataOut=16'hBEEF in the same cycle; err=0.
- Reset preserves contents: store 16'h1234 to addr 12'hFFF, pulse res for 1 cycle, then load addr 12'hFFF -> dataOut=16'h1234; busy=0, err=0.
- Clear sweep: preload addrs 0, 100 and 4095 with nonzero data, then assert clrData for 1 cycle -> busy=1 for exactly 4096 cycles. Afterwards, loads of all three addresses return 16'h0000.
- Access while busy: 10 cycles into a sweep, store 16'hAAAA to addr 12'hFF0 -> err=1 and the store is dropped. After the sweep, addr 12'hFF0 reads 0.
- Clear retrigger: assert clrData at sweep cycle 0 and again at cycle 2000 -> busy stays high for 2000+4096 cycles in total.
- res mid-sweep: assert res at sweep cycle 50 -> busy=0 next cycle. Addrs 0-49 read 0, and addr 50 onward keep their preloaded values.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared definitions for the data RAM responder.
// - state_t     : sweep FSM encoding (IDLE / CLEARING)
// - DEF_ADDR_W  : default CPU data address width
// - DEF_DATA_W  : default CPU data word width
package data_memory_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/data_memory_mem_array.sv
// DEPTH x DW storage: one asynchronous read port, one synchronous write port.
// Contents have no reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : read data (combinational)
module data_memory_mem_array #(
  parameter int AW    = 12,
  parameter int DW    = 16,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Loads complete in the same cycle the CPU presents the address.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/data_memory.sv
// Data RAM responder on the CPU load/store bus, with a multi-cycle clear sweep.
// Ports:
//   clk      : system clock
//   res      : synchronous active-high reset (FSM, pointer, err; not the RAM)
//   dataAddr : word address from the CPU
//   dataIn   : store data from the CPU
//   dataOut  : load data to the CPU (combinational, 0 when no valid load)
//   selData  : access select
//   ldData   : 1 = load, 0 = store (with selData)
//   clrData  : clear request, sampled each edge
//   busy     : high while the clear sweep runs
//   err      : sticky access error (access while busy or out of range)
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              res,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  input  logic              selData,
  input  logic              ldData,
  input  logic              clrData,
  output logic              busy,
  output logic              err
);

  // One spare bit so the last-word compare never wraps.
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   clr_ptr_reg, clr_ptr_next;
  logic               err_reg, err_next;

  logic               in_range;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  assign in_range = ({1'b0, dataAddr} < DEPTH_A);

  data_memory_mem_array #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (dataAddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg   <= IDLE;
      clr_ptr_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    err_next     = err_reg;
    mem_we       = 1'b0;
    mem_waddr    = dataAddr;
    mem_wdata    = dataIn;

    case (state_reg)
      IDLE: begin
        if (clrData) begin
          // Clear wins over a coincident access; that access raises no error.
          state_next   = CLEARING;
          clr_ptr_next = '0;
        end else if (selData) begin
          if (!in_range) begin
            err_next = 1'b1;
          end else if (!ldData) begin
            mem_we = 1'b1;
          end
        end
      end

      CLEARING: begin
        mem_we    = 1'b1;
        mem_waddr = ADDR_W'(clr_ptr_reg);
        mem_wdata = '0;
        if (selData) begin
          err_next = 1'b1;
        end
        if (clrData) begin
          // Restart: the word at the current pointer is still zeroed.
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr_reg + PTR_W'(1);
          if (clr_ptr_reg == LAST_PTR) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset leaves memory contents untouched.
    if (res) begin
      mem_we = 1'b0;
    end
  end

  assign busy    = (state_reg == CLEARING);
  assign err     = err_reg;
  assign dataOut = (selData && ldData && (state_reg == IDLE) && in_range) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          res;
  logic [AW-1:0] dataAddr;
  logic [DW-1:0] dataIn;
  logic [DW-1:0] dataOut;
  logic          selData;
  logic          ldData;
  logic          clrData;
  logic          busy;
  logic          err;

  int checks = 0;
  int passes = 0;

  // Reference model: plain word array, updated per transaction.
  logic [DW-1:0] model [DEPTH];

  data_memory #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .res      (res),
    .dataAddr (dataAddr),
    .dataIn   (dataIn),
    .dataOut  (dataOut),
    .selData  (selData),
    .ldData   (ldData),
    .clrData  (clrData),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    selData  = 1'b1;
    ldData   = 1'b0;
    dataAddr = a;
    dataIn   = d;
    #1;
    check("store_dataout_zero", dataOut, 0);
    step();
    selData = 1'b0;
    model[a] = d;
    $display("store addr=%h data=%h", a, d);
  endtask

  task automatic do_load(input string tag, input logic [AW-1:0] a);
    selData  = 1'b1;
    ldData   = 1'b1;
    dataAddr = a;
    #1;
    check(tag, dataOut, model[a]);
    $display("load  addr=%h data=%h exp=%h", a, dataOut, model[a]);
    step();
    selData = 1'b0;
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    int n;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    res = 1'b1; dataAddr = '0; dataIn = '0; selData = 1'b0; ldData = 1'b0; clrData = 1'b0;
    step(); step();
    res = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_dataout", dataOut, 0);

    // Initial full sweep gives the model a known all-zero image.
    clrData = 1'b1; step(); clrData = 1'b0;
    n = 0;
    while (busy && n < 10000) begin n++; step(); end
    check("sweep_len_initial", n, DEPTH);
    $display("sweep busy_cycles=%0d", n);
    zero_model();

    // Store then load.
    do_store(12'h005, 16'hBEEF);
    do_load("load_beef", 12'h005);
    check("err_after_store_load", err, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 200; k++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      rd = DW'($urandom);
      case ($urandom_range(0, 3))
        0: do_store(ra, rd);
        1: do_load("rand_load", ra);
        2: begin do_store(ra, rd); do_load("rand_raw", ra); end
        default: begin
          selData = 1'b0; ldData = 1'b1; dataAddr = ra; #1;
          check("idle_dataout", dataOut, 0);
          step();
        end
      endcase
    end
    check("err_after_random", err, 0);

    // Access while busy, plus clear-sweep result on preloaded words.
    do_store(12'h000, 16'h1111);
    do_store(12'd100, 16'h2222);
    do_store(12'hFFF, 16'h3333);
    do_store(12'hFF0, 16'h4444);
    clrData = 1'b1; step(); clrData = 1'b0;
    n = 0;
    while (busy && n < 10000) begin
      selData = 1'b0;
      if (n == 10) begin
        selData = 1'b1; ldData = 1'b0; dataAddr = 12'hFF0; dataIn = 16'hAAAA;
        $display("busy store addr=ff0 data=aaaa");
      end
      if (n == 20) begin
        selData = 1'b1; ldData = 1'b1; dataAddr = 12'd100; #1;
        check("busy_load_zero", dataOut, 0);
      end
      n++;
      step();
    end
    selData = 1'b0;
    check("sweep_len_clear", n, DEPTH);
    check("err_busy_access", err, 1);
    zero_model();
    do_load("clr_addr0", 12'h000);
    do_load("clr_addr100", 12'd100);
    do_load("clr_addr4095", 12'hFFF);
    do_load("busy_store_dropped", 12'hFF0);

    // Reset preserves contents and clears err.
    do_store(12'hFFF, 16'h1234);
    res = 1'b1; step(); res = 1'b0;
    check("res_busy", busy, 0);
    check("res_err_cleared", err, 0);
    do_load("res_preserve", 12'hFFF);

    // Clear retrigger 2000 cycles after the first clear edge.
    clrData = 1'b1; step(); clrData = 1'b0;
    n = 0;
    while (busy && n < 20000) begin
      clrData = (n == 1999);
      n++;
      step();
    end
    clrData = 1'b0;
    check("sweep_len_retrigger", n, 2000 + DEPTH);
    $display("retrigger busy_cycles=%0d", n);
    zero_model();

    // Reset mid-sweep: only words swept before the reset edge are zeroed.
    for (int i = 0; i < 60; i++) do_store(AW'(i), DW'(16'h0100 + i));
    clrData = 1'b1; step(); clrData = 1'b0;
    n = 0;
    while (busy && n < 10000) begin
      if (n == 50) begin
        res = 1'b1; step(); res = 1'b0;
        break;
      end
      n++;
      step();
    end
    check("midsweep_reached", n, 50);
    check("midsweep_busy", busy, 0);
    check("midsweep_err", err, 0);
    for (int i = 0; i < 50; i++) model[i] = '0;
    for (int i = 0; i < 60; i++) do_load("midsweep_load", AW'(i));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
